// File: rtl/adpcm_enc_mc_if.sv
// Sample-in / code-out handshake bundle for the multi-channel IMA ADPCM encoder.
interface adpcm_enc_mc_if #(
  parameter int PCM_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [PCM_W-1:0] in_pcm;
  logic [2:0]              in_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_code;
  logic [2:0]              out_ch;

  modport slave (
    input  in_valid, in_pcm, in_ch, out_ready,
    output in_ready, out_valid, out_code, out_ch
  );

  modport master (
    output in_valid, in_pcm, in_ch, out_ready,
    input  in_ready, out_valid, out_code, out_ch
  );
endinterface

// File: rtl/adpcm_enc_mc.sv
// Multi-channel IMA ADPCM encoder, one successive-approximation bit per cycle.
// Optional predictor clamp counter enabled by defining ADPCM_CLIP_CNT_EN.
module adpcm_enc_mc #(
  parameter int NUM_CH = 2,
  parameter int PCM_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  adpcm_enc_mc_if.slave bus,
  output logic          ch_err,
  output logic [7:0]    clip_cnt
);

  localparam logic [14:0] StepTab [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };
  localparam logic [3:0] NumCh = 4'(NUM_CH);

  typedef enum logic [2:0] {StIdle, StE2, StE1, StE0, StUpd, StOut} state_e;
  state_e state_q, state_d;

  logic               started_q, ch_err_q;
  logic signed [15:0] pred_q [NUM_CH];
  logic [6:0]         idx_q  [NUM_CH];
  logic signed [15:0] x_q;
  logic [2:0]         ch_q, mag_q, och_q;
  logic               sign_q;
  logic [16:0]        diff_q, vp_q;
  logic [14:0]        step_q;
  logic [3:0]         code_q;

  logic               accept, ch_ok, hit, sat_hi, sat_lo;
  logic signed [15:0] x_in, cur_pred, new_pred;
  logic [6:0]         cur_idx, new_idx;
  logic [14:0]        tab_step, cmp_step;
  logic signed [16:0] diff_full;
  logic [16:0]        cmp_diff;
  logic signed [17:0] pred_s, vp_s, sum;
  logic signed [7:0]  idx_adj, idx_sum;

  assign bus.in_ready  = started_q && (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_code  = code_q;
  assign bus.out_ch    = och_q;
  assign ch_err        = ch_err_q;

  assign ch_ok  = {1'b0, bus.in_ch} < NumCh;
  assign accept = bus.in_valid && bus.in_ready && !clr;
  assign x_in   = 16'(bus.in_pcm) << (16 - PCM_W);

  always_comb begin
    cur_pred = '0;
    cur_idx  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 3'(c)) begin
        cur_pred = pred_q[c];
        cur_idx  = idx_q[c];
      end
    end
  end

  // Successive-approximation datapath: E2 starts from |x-pred| and the full step,
  // E1/E0 refine with the halved and quartered step.
  always_comb begin
    tab_step  = StepTab[cur_idx];
    diff_full = 17'(x_q) - 17'(cur_pred);
    if (state_q == StE2) begin
      cmp_diff = diff_full[16] ? 17'(-diff_full) : 17'(diff_full);
      cmp_step = tab_step;
    end else begin
      cmp_diff = diff_q;
      cmp_step = (state_q == StE1) ? (step_q >> 1) : (step_q >> 2);
    end
    hit = cmp_diff >= 17'(cmp_step);
  end

  always_comb begin
    pred_s   = 18'(cur_pred);
    vp_s     = $signed({1'b0, vp_q});
    sum      = sign_q ? (pred_s - vp_s) : (pred_s + vp_s);
    sat_hi   = sum > 18'sd32767;
    sat_lo   = sum < -18'sd32768;
    new_pred = sat_hi ? 16'sh7fff : (sat_lo ? 16'sh8000 : sum[15:0]);
    idx_adj  = mag_q[2] ? {4'b0000, 3'({1'b0, mag_q[1:0]} + 3'd1), 1'b0} : 8'hff;
    idx_sum  = $signed({1'b0, cur_idx}) + idx_adj;
    if (idx_sum < 8'sd0)       new_idx = 7'd0;
    else if (idx_sum > 8'sd88) new_idx = 7'd88;
    else                       new_idx = idx_sum[6:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && ch_ok) state_d = StE2;
      StE2:   state_d = StE1;
      StE1:   state_d = StE0;
      StE0:   state_d = StUpd;
      StUpd:  state_d = StOut;
      StOut:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      x_q       <= '0;
      ch_q      <= '0;
      sign_q    <= 1'b0;
      diff_q    <= '0;
      vp_q      <= '0;
      step_q    <= '0;
      mag_q     <= '0;
      code_q    <= '0;
      och_q     <= '0;
    end else begin
      started_q <= 1'b1;
      if (accept) begin
        x_q  <= x_in;
        ch_q <= bus.in_ch;
      end
      if (state_q inside {StE2, StE1, StE0}) begin
        diff_q <= hit ? (cmp_diff - 17'(cmp_step)) : cmp_diff;
        vp_q   <= ((state_q == StE2) ? 17'(tab_step >> 3) : vp_q) +
                  (hit ? 17'(cmp_step) : 17'd0);
        mag_q  <= {(state_q == StE2) ? 2'b00 : mag_q[1:0], hit};
        if (state_q == StE2) begin
          step_q <= tab_step;
          sign_q <= diff_full[16];
        end
      end
      if (state_q == StUpd && !clr) begin
        code_q <= {sign_q, mag_q};
        och_q  <= ch_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_err_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        pred_q[c] <= '0;
        idx_q[c]  <= '0;
      end
    end else if (clr) begin
      ch_err_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        pred_q[c] <= '0;
        idx_q[c]  <= '0;
      end
    end else begin
      // Out-of-range tags are swallowed: flag only, FSM stays idle.
      if (accept && !ch_ok) ch_err_q <= 1'b1;
      if (state_q == StUpd) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_q == 3'(c)) begin
            pred_q[c] <= new_pred;
            idx_q[c]  <= new_idx;
          end
        end
      end
    end
  end

`ifdef ADPCM_CLIP_CNT_EN
  logic [7:0] clip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= '0;
    end else if (clr) begin
      clip_q <= '0;
    end else if (state_q == StUpd && (sat_hi || sat_lo) && clip_q != 8'hff) begin
      clip_q <= clip_q + 8'd1;
    end
  end

  assign clip_cnt = clip_q;
`else
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_adpcm_enc_mc.sv
// Scoreboard bench for adpcm_enc_mc: random samples checked against an IMA reference model.
module tb_adpcm_enc_mc;
  localparam int NUM_CH = 2;
  localparam int PCM_W  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       ch_err;
  logic [7:0] clip_cnt;

  adpcm_enc_mc_if #(.PCM_W(PCM_W)) bus ();

  adpcm_enc_mc #(.NUM_CH(NUM_CH), .PCM_W(PCM_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus),
    .ch_err   (ch_err),
    .clip_cnt (clip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [2:0] ch;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rnd_ready = 1'b0;

  int step_tab[89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
    279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
    1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428,
    4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289,
    16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int idx_adj[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  int m_pred[8];
  int m_idx[8];
  int m_clip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pred[i] = 0;
      m_idx[i]  = 0;
    end
    m_clip = 0;
  endtask

  task automatic model_enc(input int ch, input logic signed [15:0] pcm, output logic [3:0] code);
    int x, step, diff, vp, mag, p;
    bit neg;
    x    = int'(pcm);
    step = step_tab[m_idx[ch]];
    diff = x - m_pred[ch];
    neg  = diff < 0;
    if (neg) diff = -diff;
    mag = 0;
    vp  = step / 8;
    if (diff >= step)     begin mag += 4; diff -= step;     vp += step;     end
    if (diff >= step / 2) begin mag += 2; diff -= step / 2; vp += step / 2; end
    if (diff >= step / 4) begin mag += 1;                   vp += step / 4; end
    p = neg ? m_pred[ch] - vp : m_pred[ch] + vp;
    if (p > 32767)       begin p = 32767;  m_clip++; end
    else if (p < -32768) begin p = -32768; m_clip++; end
    m_pred[ch] = p;
    m_idx[ch]  = m_idx[ch] + idx_adj[mag];
    if (m_idx[ch] < 0)  m_idx[ch] = 0;
    if (m_idx[ch] > 88) m_idx[ch] = 88;
    code = {neg, 3'(mag)};
  endtask

  // Handshake one sample into the DUT; returns just after the transfer edge.
  task automatic xfer(input logic [2:0] ch, input logic signed [15:0] pcm, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) begin
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_pcm   = pcm;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] ch, input logic signed [15:0] pcm);
    logic [3:0] c;
    exp_t       e;
    bit         ok;
    int         lat;
    xfer(ch, pcm, ok);
    if (!ok) return;
    model_enc(int'(ch), pcm, c);
    e.code = c;
    e.ch   = ch;
    q.push_back(e);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_latency", 32'(lat), 32'd4);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("out_code", 32'(bus.out_code), 32'(e.code));
          check("out_ch", 32'(bus.out_ch), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   bad;
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.in_pcm    = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_code", 32'(bus.out_code), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_ch_err", 32'(ch_err), 32'd0);
    check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Known IMA sequence: 0, +100, ch1 -100, +100 again.
    send(3'd0, 16'sd0);
    send(3'd0, 16'sd100);
    send(3'd1, -16'sd100);
    send(3'd0, 16'sd100);
    drain();

    // Backpressure: hold out_ready low for 10 cycles in OUT.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(3'd1, -16'sd2000);
    e   = q[0];
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_code !== e.code || bus.out_ch !== e.ch || bus.in_ready)
        bad++;
    end
    check("backpressure_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, NUM_CH - 1)), 16'($urandom));
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // Out-of-range channel: swallowed, sticky error.
    xfer(3'd5, 16'sd77, ok);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("bad_ch_no_output", 32'(bad), 32'd0);
    check("ch_err_set", 32'(ch_err), 32'd1);
    send(3'd1, 16'sd300);
    drain();
    check("ch_err_sticky", 32'(ch_err), 32'd1);

    // Clear during E1 of a valid sample.
    xfer(3'd0, 16'sd5000, ok);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("clr_no_output", 32'(bad), 32'd0);
    check("clr_ch_err", 32'(ch_err), 32'd0);
    check("clr_clip_cnt", 32'(clip_cnt), 32'd0);
    send(3'd0, 16'sd0);
    drain();

    // Full-scale run into predictor saturation and index ceiling.
    rnd_ready = 1'b1;
    repeat (100) send(3'd0, 16'sd32767);
    drain();
`ifdef ADPCM_CLIP_CNT_EN
    check("clip_cnt", 32'(clip_cnt), 32'((m_clip > 255) ? 255 : m_clip));
    check("clip_nonzero", 32'(clip_cnt != 8'd0), 32'd1);
`else
    check("clip_cnt", 32'(clip_cnt), 32'd0);
`endif
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // Reset mid-operation discards the in-flight sample and all channel state.
    xfer(3'd0, 16'sd1234, ok);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_in_ready_back", 32'(bus.in_ready), 32'd1);
    send(3'd0, 16'sd100);
    send(3'd1, -16'sd100);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
